stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_unit_pkg.sv | 21 ++
 rtl/stack_ram.sv | 27 ++
 rtl/stack_unit.sv | 186 ++++++++++++++++++
 tb/tb_stack_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared definitions for the data stack: operation encodings used by the
// CPU decoder and by stack_unit.
package stack_unit_pkg;

   typedef enum logic [2:0] {
      OP_NOP      = 3'd0,
      OP_PUSH     = 3'd1,
      OP_POP      = 3'd2,
      OP_POP2PUSH = 3'd3,
      OP_SWAP     = 3'd4,
      OP_DUP      = 3'd5,
      OP_OVER     = 3'd6,
      OP_DROP2    = 3'd7
   } stack_op_e;

   // Address width for a memory of n entries (at least one bit).
   function automatic int addr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Spill memory for stack entries below NOS: one synchronous write port and
// one combinational read port, no reset (contents are don't-care after reset).
module stack_ram #(
   parameter int DEPTH = 14,
   parameter int WIDTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the spilled entry on the rising edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_unit.sv
// Hardware data stack: TOS and NOS live in registers, deeper entries spill
// to stack_ram indexed by count-3. Illegal operations are rejected and
// raise sticky overflow/underflow flags.
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       op_valid,
   input  logic [2:0]                 op,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       err_clr,
   output logic [WIDTH-1:0]           tos,
   output logic [WIDTH-1:0]           nos,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW        = $clog2(DEPTH + 1);
   localparam int RAM_DEPTH = DEPTH - 2;
   localparam int AW        = addr_bits(RAM_DEPTH);

   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [CW-1:0] C_TWO   = CW'(2);
   localparam logic [CW-1:0] C_THREE = CW'(3);
   localparam logic [CW-1:0] C_FOUR  = CW'(4);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] tos_q, tos_d;
   logic [WIDTH-1:0] nos_q, nos_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             set_ovf, set_unf;
   logic             do_push;
   logic [WIDTH-1:0] push_val;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    rd_addr [2];
   logic [WIDTH-1:0] rd_data [2];

   stack_op_e        op_c;

   assign op_c = stack_op_e'(op);

   // Bank 0 reads the array top (count-3), bank 1 the entry below it
   // (count-4); DROP2 needs both in the same cycle, so the banks are
   // written identically and each keeps a single read port.
   assign rd_addr[0] = (count_q >= C_THREE) ? AW'(count_q - C_THREE) : '0;
   assign rd_addr[1] = (count_q >= C_FOUR)  ? AW'(count_q - C_FOUR)  : '0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         stack_ram #(
            .DEPTH (RAM_DEPTH),
            .WIDTH (WIDTH),
            .AW    (AW)
         ) u_stack_ram (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_addr (rd_addr[gi]),
            .rd_data (rd_data[gi])
         );
      end
   endgenerate

   // Decode the operation, check its preconditions and compute next state.
   always_comb begin
      tos_d    = tos_q;
      nos_d    = nos_q;
      count_d  = count_q;
      set_ovf  = 1'b0;
      set_unf  = 1'b0;
      do_push  = 1'b0;
      push_val = push_data;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = nos_q;

      if (op_valid) begin
         case (op_c)
            OP_PUSH: begin
               if (count_q < C_DEPTH) do_push = 1'b1;
               else                   set_ovf = 1'b1;
            end
            OP_POP: begin
               if (count_q >= C_ONE) begin
                  tos_d   = nos_q;
                  nos_d   = (count_q >= C_THREE) ? rd_data[0] : '0;
                  count_d = count_q - C_ONE;
               end else begin
                  set_unf = 1'b1;
               end
            end
            OP_POP2PUSH: begin
               if (count_q >= C_TWO) begin
                  tos_d   = push_data;
                  nos_d   = (count_q >= C_THREE) ? rd_data[0] : '0;
                  count_d = count_q - C_ONE;
               end else begin
                  set_unf = 1'b1;
               end
            end
            OP_SWAP: begin
               if (count_q >= C_TWO) begin
                  tos_d = nos_q;
                  nos_d = tos_q;
               end else begin
                  set_unf = 1'b1;
               end
            end
            OP_DUP: begin
               push_val = tos_q;
               if (count_q < C_ONE)         set_unf = 1'b1;
               else if (count_q >= C_DEPTH) set_ovf = 1'b1;
               else                         do_push = 1'b1;
            end
            OP_OVER: begin
               push_val = nos_q;
               if (count_q < C_TWO)         set_unf = 1'b1;
               else if (count_q >= C_DEPTH) set_ovf = 1'b1;
               else                         do_push = 1'b1;
            end
            OP_DROP2: begin
               if (count_q >= C_TWO) begin
                  tos_d   = (count_q >= C_THREE) ? rd_data[0] : '0;
                  nos_d   = (count_q >= C_FOUR)  ? rd_data[1] : '0;
                  count_d = count_q - C_TWO;
               end else begin
                  set_unf = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Common growth path: NOS spills to the array once the registers are full.
      if (do_push) begin
         if (count_q >= C_TWO) begin
            wr_en   = 1'b1;
            wr_addr = AW'(count_q - C_TWO);
         end
         nos_d   = tos_q;
         tos_d   = push_val;
         count_d = count_q + C_ONE;
      end

      // A new error in the same cycle as err_clr keeps the flag set.
      ovf_d = (ovf_q & ~err_clr) | set_ovf;
      unf_d = (unf_q & ~err_clr) | set_unf;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tos_q   <= '0;
         nos_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         nos_q   <= nos_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign tos       = (count_q >= C_ONE) ? tos_q : '0;
   assign nos       = (count_q >= C_TWO) ? nos_q : '0;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus random
// operations compared against a queue-based model of the stack.
module tb_stack_unit;

   localparam int DEPTH = 16;
   localparam int WIDTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst_n;
   logic             op_valid;
   logic [2:0]       op;
   logic [WIDTH-1:0] push_data;
   logic             err_clr;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   int errors = 0;
   int checks = 0;

   // Reference model: the stack as a queue, last element is the top.
   int unsigned mq[$];
   bit          m_ovf;
   bit          m_unf;

   stack_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_valid  (op_valid),
      .op        (op),
      .push_data (push_data),
      .err_clr   (err_clr),
      .tos       (tos),
      .nos       (nos),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int unsigned e_tos, e_nos;
      int n;
      n     = mq.size();
      e_tos = (n >= 1) ? mq[n-1] : 0;
      e_nos = (n >= 2) ? mq[n-2] : 0;
      check({tag, ".tos"},       32'(tos),       32'(e_tos));
      check({tag, ".nos"},       32'(nos),       32'(e_nos));
      check({tag, ".count"},     32'(count),     32'(n));
      check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
      check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
   endtask

   // Apply one accepted operation to the model, from the stack rules only.
   task automatic model_apply(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic clr);
      int  n;
      bit  so, su;
      int unsigned a, b;
      n  = mq.size();
      so = 0;
      su = 0;
      case (o)
         3'd1: if (n < DEPTH) mq.push_back(d); else so = 1;
         3'd2: if (n >= 1) void'(mq.pop_back()); else su = 1;
         3'd3: if (n >= 2) begin
                  void'(mq.pop_back());
                  void'(mq.pop_back());
                  mq.push_back(d);
               end else su = 1;
         3'd4: if (n >= 2) begin
                  a = mq.pop_back();
                  b = mq.pop_back();
                  mq.push_back(a);
                  mq.push_back(b);
               end else su = 1;
         3'd5: if (n < 1) su = 1;
               else if (n >= DEPTH) so = 1;
               else mq.push_back(mq[n-1]);
         3'd6: if (n < 2) su = 1;
               else if (n >= DEPTH) so = 1;
               else mq.push_back(mq[n-2]);
         3'd7: if (n >= 2) begin
                  void'(mq.pop_back());
                  void'(mq.pop_back());
               end else su = 1;
         default: ;
      endcase
      m_ovf = (m_ovf && !clr) || so;
      m_unf = (m_unf && !clr) || su;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic clr);
      @(negedge clk);
      op_valid  = 1'b1;
      op        = o;
      push_data = d;
      err_clr   = clr;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      err_clr  = 1'b0;
      model_apply(o, d, clr);
      $display("op=%0d data=%04h clr=%0b -> tos=%04h nos=%04h count=%0d ovf=%0b unf=%0b",
               o, d, clr, tos, nos, count, overflow, underflow);
      check_all($sformatf("op%0d", o));
   endtask

   // A cycle with op_valid low: whatever op is on the bus must be ignored.
   task automatic run_idle(input logic [2:0] o, input logic [WIDTH-1:0] d);
      @(negedge clk);
      op_valid  = 1'b0;
      op        = o;
      push_data = d;
      err_clr   = 1'b0;
      @(posedge clk);
      #1;
      $display("idle op=%0d -> tos=%04h nos=%04h count=%0d", o, tos, nos, count);
      check_all("idle");
   endtask

   initial begin
      rst_n     = 1'b0;
      op_valid  = 1'b0;
      op        = 3'd0;
      push_data = '0;
      err_clr   = 1'b0;
      m_ovf     = 0;
      m_unf     = 0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // PUSH 5, PUSH 7, then POP2PUSH 12.
      run_op(3'd1, 16'd5, 1'b0);
      run_op(3'd1, 16'd7, 1'b0);
      run_op(3'd3, 16'd12, 1'b0);
      run_op(3'd2, 16'd0, 1'b0);

      // Fill past DEPTH, then drain in LIFO order.
      for (int i = 1; i <= 18; i++) run_op(3'd1, 16'(i), 1'b0);
      run_op(3'd0, 16'd0, 1'b1);
      for (int i = 0; i < 16; i++) run_op(3'd2, 16'd0, 1'b0);

      // Underflow, clear, and underflow again via SWAP at count=1.
      run_op(3'd2, 16'd0, 1'b0);
      run_op(3'd0, 16'd0, 1'b1);
      run_op(3'd1, 16'h00aa, 1'b0);
      run_op(3'd4, 16'd0, 1'b0);
      run_op(3'd7, 16'd0, 1'b1);
      run_op(3'd2, 16'd0, 1'b0);
      run_op(3'd0, 16'd0, 1'b1);

      // PUSH 3, PUSH 4, OVER, SWAP, DROP2.
      run_op(3'd1, 16'd3, 1'b0);
      run_op(3'd1, 16'd4, 1'b0);
      run_op(3'd6, 16'd0, 1'b0);
      run_op(3'd4, 16'd0, 1'b0);
      run_op(3'd7, 16'd0, 1'b0);
      run_idle(3'd1, 16'hbeef);

      // Random operations, biased toward PUSH so the array is exercised.
      for (int i = 0; i < 400; i++) begin
         logic [2:0] ro;
         ro = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) ro = 3'd1;
         if ($urandom_range(0, 19) == 0)
            run_idle(ro, 16'($urandom));
         else
            run_op(ro, 16'($urandom), 1'($urandom_range(0, 15) == 0));
      end

      // Bring the stack to count=9, then assert reset between edges.
      while (mq.size() > 9) run_op(3'd2, 16'd0, 1'b0);
      while (mq.size() < 9) run_op(3'd1, 16'($urandom), 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      $display("async reset -> tos=%04h nos=%04h count=%0d", tos, nos, count);
      check_all("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'd1, 16'h0055, 1'b0);
      run_op(3'd2, 16'd0, 1'b0);
      run_op(3'd2, 16'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
